// File: rtl/dram_write_coalescer_if.sv
// Signal bundle between the write pipeline, the write coalescer and the DRAM write port.
// The slave modport is the coalescer's view; master is the view of whoever drives both neighbours.
interface dram_write_coalescer_if #(
    parameter int GBW    = 32,
    parameter int DBW    = 16,
    parameter int CSIZE  = 32,
    parameter int CNT_BW = 16
);
    logic              dramw_rdy;
    logic              dramw_ack;
    logic [GBW-1:0]    i_dramwa;
    logic [DBW-1:0]    i_dramwd [CSIZE];
    logic [CSIZE-1:0]  i_dramw_mask;

    logic              mem_rdy;
    logic              mem_ack;
    logic [GBW-1:0]    o_mema;
    logic [DBW-1:0]    o_memd [CSIZE];
    logic [CSIZE-1:0]  o_mem_mask;

    logic              o_idle;
    logic [CNT_BW-1:0] o_merge_cnt;

    modport slave (
        input  dramw_rdy, i_dramwa, i_dramwd, i_dramw_mask, mem_ack,
        output dramw_ack, mem_rdy, o_mema, o_memd, o_mem_mask, o_idle, o_merge_cnt
    );

    modport master (
        output dramw_rdy, i_dramwa, i_dramwd, i_dramw_mask, mem_ack,
        input  dramw_ack, mem_rdy, o_mema, o_memd, o_mem_mask, o_idle, o_merge_cnt
    );
endinterface

// File: rtl/dram_write_coalescer.sv
// Small write FIFO in front of the DRAM write port that folds same-line requests into the
// youngest queued entry, with an idle flag for drain detection and a saturating merge counter.
module dram_write_coalescer #(
    parameter int GBW    = 32,
    parameter int DBW    = 16,
    parameter int CSIZE  = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_BW = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    dram_write_coalescer_if.slave  bus
);
    localparam int            PW       = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW + 1)'(DEPTH);
    localparam logic [PW:0]   TWO_CNT  = (PW + 1)'(2);

    logic [GBW-1:0]    addr_q [DEPTH];
    logic [DBW-1:0]    data_q [DEPTH][CSIZE];
    logic [CSIZE-1:0]  mask_q [DEPTH];

    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [PW-1:0]     last;
    logic [PW:0]       count;
    logic [CNT_BW-1:0] merge_cnt;

    logic              zero_mask;
    logic              hit;
    logic              accept;
    logic              push;
    logic              merge;
    logic              pop;

    // Only the youngest entry may absorb a request, and never while it is also the head,
    // so the entry DRAM is currently looking at stays frozen and write order is preserved.
    assign last      = tail - 1'b1;
    assign zero_mask = (bus.i_dramw_mask == '0);
    assign hit       = (count >= TWO_CNT) && (bus.i_dramwa == addr_q[last]);

    assign accept = !i_rst && bus.dramw_rdy && (zero_mask || hit || (count < FULL_CNT));
    assign push   = accept && !zero_mask && !hit;
    assign merge  = accept && !zero_mask && hit;
    assign pop    = bus.mem_ack && (count != '0);

    assign bus.dramw_ack   = accept;
    assign bus.mem_rdy     = !i_rst && (count != '0);
    assign bus.o_idle      = i_rst || (count == '0);
    assign bus.o_merge_cnt = i_rst ? '0 : merge_cnt;
    assign bus.o_mema      = addr_q[head];
    assign bus.o_mem_mask  = mask_q[head];
    assign bus.o_memd      = data_q[head];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            merge_cnt <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (merge && (merge_cnt != '1)) begin
                merge_cnt <= merge_cnt + 1'b1;
            end
        end
    end

    // Payload storage carries no reset; an entry only becomes visible once count covers it.
    always_ff @(posedge i_clk) begin
        if (push) begin
            addr_q[tail] <= bus.i_dramwa;
            mask_q[tail] <= bus.i_dramw_mask;
            for (int i = 0; i < CSIZE; i++) begin
                data_q[tail][i] <= bus.i_dramwd[i];
            end
        end else if (merge) begin
            mask_q[last] <= mask_q[last] | bus.i_dramw_mask;
            for (int i = 0; i < CSIZE; i++) begin
                if (bus.i_dramw_mask[i]) begin
                    data_q[last][i] <= bus.i_dramwd[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_dram_write_coalescer.sv
// Directed bench for dram_write_coalescer: one task per scenario, hand-computed expectations.
module tb_dram_write_coalescer;
    localparam int GBW    = 32;
    localparam int DBW    = 16;
    localparam int CSIZE  = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_BW = 16;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    dram_write_coalescer_if #(.GBW(GBW), .DBW(DBW), .CSIZE(CSIZE), .CNT_BW(CNT_BW)) bus ();

    dram_write_coalescer #(
        .GBW(GBW), .DBW(DBW), .CSIZE(CSIZE), .DEPTH(DEPTH), .CNT_BW(CNT_BW)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DRAM must never be acked while it has nothing to take.
    always @(posedge clk) begin
        if (!rst && bus.mem_ack && !bus.mem_rdy) begin
            bad++;
            $display("[TB] FAIL protocol mem_ack=%0b while mem_rdy=%0b", bus.mem_ack, bus.mem_rdy);
        end
    end

    task automatic set_req(input logic [31:0] a, input logic [31:0] m, input logic [15:0] v);
        bus.dramw_rdy    = 1'b1;
        bus.i_dramwa     = a;
        bus.i_dramw_mask = m;
        for (int i = 0; i < CSIZE; i++) bus.i_dramwd[i] = v;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.mem_ack = 1'b0;
        set_req(32'h5, 32'h1, 16'h0);
        @(negedge clk);
        @(negedge clk);
        #1;
        total++; if (bus.dramw_ack !== 1'b0) begin bad++; $display("[TB] FAIL rst_ack got=%0b want=0", bus.dramw_ack); end
        total++; if (bus.mem_rdy !== 1'b0) begin bad++; $display("[TB] FAIL rst_mem_rdy got=%0b want=0", bus.mem_rdy); end
        total++; if (bus.o_idle !== 1'b1) begin bad++; $display("[TB] FAIL rst_idle got=%0b want=1", bus.o_idle); end
        total++; if (bus.o_merge_cnt !== 16'h0) begin bad++; $display("[TB] FAIL rst_cnt got=%h want=0000", bus.o_merge_cnt); end
        rst = 1'b0;
        bus.dramw_rdy = 1'b0;
    endtask

    task automatic test_passthrough();
        @(negedge clk);
        set_req(32'h100, 32'hFFFF_FFFF, 16'h1234);
        #1;
        total++; if (bus.dramw_ack !== 1'b1) begin bad++; $display("[TB] FAIL pt_ack got=%0b want=1", bus.dramw_ack); end
        total++; if (bus.mem_rdy !== 1'b0) begin bad++; $display("[TB] FAIL pt_no_bypass got=%0b want=0", bus.mem_rdy); end
        @(negedge clk);
        bus.dramw_rdy = 1'b0;
        #1;
        total++; if (bus.mem_rdy !== 1'b1) begin bad++; $display("[TB] FAIL pt_mem_rdy got=%0b want=1", bus.mem_rdy); end
        total++; if (bus.o_mema !== 32'h100) begin bad++; $display("[TB] FAIL pt_addr got=%h want=00000100", bus.o_mema); end
        total++; if (bus.o_memd[5] !== 16'h1234) begin bad++; $display("[TB] FAIL pt_data got=%h want=1234", bus.o_memd[5]); end
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        #1;
        total++; if (bus.o_idle !== 1'b1) begin bad++; $display("[TB] FAIL pt_idle got=%0b want=1", bus.o_idle); end
        total++; if (bus.o_merge_cnt !== 16'd0) begin bad++; $display("[TB] FAIL pt_cnt got=%0d want=0", bus.o_merge_cnt); end
    endtask

    task automatic test_merge();
        @(negedge clk);
        set_req(32'h10, 32'h0000_0001, 16'h0001);
        @(negedge clk);
        set_req(32'h20, 32'h0000_FFFF, 16'hAAAA);
        @(negedge clk);
        set_req(32'h20, 32'hFFFF_0000, 16'hBBBB);
        #1;
        total++; if (bus.dramw_ack !== 1'b1) begin bad++; $display("[TB] FAIL mg_ack got=%0b want=1", bus.dramw_ack); end
        @(negedge clk);
        bus.dramw_rdy = 1'b0;
        #1;
        total++; if (bus.o_merge_cnt !== 16'd1) begin bad++; $display("[TB] FAIL mg_cnt got=%0d want=1", bus.o_merge_cnt); end
        total++; if (bus.o_mema !== 32'h10) begin bad++; $display("[TB] FAIL mg_head got=%h want=00000010", bus.o_mema); end
        bus.mem_ack = 1'b1;
        @(negedge clk);
        #1;
        total++; if (bus.o_mema !== 32'h20) begin bad++; $display("[TB] FAIL mg_second got=%h want=00000020", bus.o_mema); end
        total++; if (bus.o_mem_mask !== 32'hFFFF_FFFF) begin bad++; $display("[TB] FAIL mg_mask got=%h want=ffffffff", bus.o_mem_mask); end
        total++; if (bus.o_memd[0] !== 16'hAAAA) begin bad++; $display("[TB] FAIL mg_d0 got=%h want=aaaa", bus.o_memd[0]); end
        total++; if (bus.o_memd[15] !== 16'hAAAA) begin bad++; $display("[TB] FAIL mg_d15 got=%h want=aaaa", bus.o_memd[15]); end
        total++; if (bus.o_memd[16] !== 16'hBBBB) begin bad++; $display("[TB] FAIL mg_d16 got=%h want=bbbb", bus.o_memd[16]); end
        total++; if (bus.o_memd[31] !== 16'hBBBB) begin bad++; $display("[TB] FAIL mg_d31 got=%h want=bbbb", bus.o_memd[31]); end
        @(negedge clk);
        bus.mem_ack = 1'b0;
        #1;
        total++; if (bus.o_idle !== 1'b1) begin bad++; $display("[TB] FAIL mg_two_entries idle got=%0b want=1", bus.o_idle); end
    endtask

    task automatic test_head_protection();
        @(negedge clk);
        set_req(32'h40, 32'h0000_000F, 16'h0011);
        @(negedge clk);
        set_req(32'h40, 32'h0000_00F0, 16'h0022);
        @(negedge clk);
        set_req(32'h40, 32'h0000_0F00, 16'h0033);
        @(negedge clk);
        bus.dramw_rdy = 1'b0;
        #1;
        total++; if (bus.o_merge_cnt !== 16'd2) begin bad++; $display("[TB] FAIL hp_cnt got=%0d want=2", bus.o_merge_cnt); end
        total++; if (bus.o_mem_mask !== 32'h0000_000F) begin bad++; $display("[TB] FAIL hp_head_mask got=%h want=0000000f", bus.o_mem_mask); end
        total++; if (bus.o_memd[0] !== 16'h0011) begin bad++; $display("[TB] FAIL hp_head_d0 got=%h want=0011", bus.o_memd[0]); end
        bus.mem_ack = 1'b1;
        @(negedge clk);
        #1;
        total++; if (bus.o_mema !== 32'h40) begin bad++; $display("[TB] FAIL hp_second_addr got=%h want=00000040", bus.o_mema); end
        total++; if (bus.o_mem_mask !== 32'h0000_0FF0) begin bad++; $display("[TB] FAIL hp_second_mask got=%h want=00000ff0", bus.o_mem_mask); end
        total++; if (bus.o_memd[4] !== 16'h0022) begin bad++; $display("[TB] FAIL hp_d4 got=%h want=0022", bus.o_memd[4]); end
        total++; if (bus.o_memd[8] !== 16'h0033) begin bad++; $display("[TB] FAIL hp_d8 got=%h want=0033", bus.o_memd[8]); end
        @(negedge clk);
        bus.mem_ack = 1'b0;
        #1;
        total++; if (bus.o_idle !== 1'b1) begin bad++; $display("[TB] FAIL hp_idle got=%0b want=1", bus.o_idle); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_addr;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_req(32'h1000 + 32'(i) * 32'h10, 32'hFFFF_FFFF, 16'(i + 1));
            #1;
            total++; if (bus.dramw_ack !== 1'b1) begin bad++; $display("[TB] FAIL bp_fill%0d got=%0b want=1", i, bus.dramw_ack); end
        end
        @(negedge clk);
        set_req(32'h1040, 32'hFFFF_FFFF, 16'h5);
        #1;
        total++; if (bus.dramw_ack !== 1'b0) begin bad++; $display("[TB] FAIL bp_full got=%0b want=0", bus.dramw_ack); end
        @(negedge clk);
        bus.mem_ack = 1'b1;
        #1;
        total++; if (bus.dramw_ack !== 1'b0) begin bad++; $display("[TB] FAIL bp_full_pop got=%0b want=0", bus.dramw_ack); end
        total++; if (bus.o_mema !== 32'h1000) begin bad++; $display("[TB] FAIL bp_first got=%h want=00001000", bus.o_mema); end
        @(negedge clk);
        bus.mem_ack = 1'b0;
        #1;
        total++; if (bus.dramw_ack !== 1'b1) begin bad++; $display("[TB] FAIL bp_after_pop got=%0b want=1", bus.dramw_ack); end
        @(negedge clk);
        bus.dramw_rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_addr = 32'h1010 + 32'(k) * 32'h10;
            #1;
            total++; if (bus.o_mema !== exp_addr || bus.mem_rdy !== 1'b1) begin bad++; $display("[TB] FAIL bp_order%0d got=%h rdy=%0b want=%h", k, bus.o_mema, bus.mem_rdy, exp_addr); end
            bus.mem_ack = 1'b1;
            @(negedge clk);
        end
        bus.mem_ack = 1'b0;
        #1;
        total++; if (bus.o_idle !== 1'b1) begin bad++; $display("[TB] FAIL bp_idle got=%0b want=1", bus.o_idle); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        set_req(32'h80, 32'h1, 16'h0002);
        @(negedge clk);
        set_req(32'h90, 32'h1, 16'h0002);
        @(negedge clk);
        set_req(32'h90, 32'h2, 16'h0003);
        bus.mem_ack = 1'b1;
        #1;
        total++; if (bus.dramw_ack !== 1'b1) begin bad++; $display("[TB] FAIL bb_merge_pop_ack got=%0b want=1", bus.dramw_ack); end
        @(negedge clk);
        set_req(32'hA0, 32'h1, 16'h0004);
        #1;
        total++; if (bus.o_mema !== 32'h90) begin bad++; $display("[TB] FAIL bb_addr got=%h want=00000090", bus.o_mema); end
        total++; if (bus.o_mem_mask !== 32'h3) begin bad++; $display("[TB] FAIL bb_mask got=%h want=00000003", bus.o_mem_mask); end
        total++; if (bus.o_memd[1] !== 16'h0003) begin bad++; $display("[TB] FAIL bb_d1 got=%h want=0003", bus.o_memd[1]); end
        total++; if (bus.o_merge_cnt !== 16'd3) begin bad++; $display("[TB] FAIL bb_cnt got=%0d want=3", bus.o_merge_cnt); end
        @(negedge clk);
        bus.dramw_rdy = 1'b0;
        #1;
        total++; if (bus.o_mema !== 32'hA0 || bus.mem_rdy !== 1'b1) begin bad++; $display("[TB] FAIL bb_pushpop got=%h rdy=%0b want=000000a0", bus.o_mema, bus.mem_rdy); end
        @(negedge clk);
        bus.mem_ack = 1'b0;
        #1;
        total++; if (bus.o_idle !== 1'b1) begin bad++; $display("[TB] FAIL bb_idle got=%0b want=1", bus.o_idle); end
    endtask

    task automatic test_zero_mask_saturation();
        @(negedge clk);
        set_req(32'h50, 32'h0, 16'h0);
        #1;
        total++; if (bus.dramw_ack !== 1'b1) begin bad++; $display("[TB] FAIL zm_ack got=%0b want=1", bus.dramw_ack); end
        @(negedge clk);
        set_req(32'h60, 32'h1, 16'h0006);
        #1;
        total++; if (bus.o_idle !== 1'b1) begin bad++; $display("[TB] FAIL zm_no_entry got=%0b want=1", bus.o_idle); end
        @(negedge clk);
        set_req(32'h70, 32'h1, 16'h0007);
        @(negedge clk);
        set_req(32'h70, 32'h0, 16'h0);
        #1;
        total++; if (bus.dramw_ack !== 1'b1) begin bad++; $display("[TB] FAIL zm_hit_ack got=%0b want=1", bus.dramw_ack); end
        @(negedge clk);
        set_req(32'h70, 32'h1, 16'h0008);
        #1;
        total++; if (bus.o_merge_cnt !== 16'd3) begin bad++; $display("[TB] FAIL zm_no_merge got=%0d want=3", bus.o_merge_cnt); end
        repeat (100) @(negedge clk);
        #1;
        total++; if (bus.o_merge_cnt !== 16'd103) begin bad++; $display("[TB] FAIL sat_mid got=%0d want=103", bus.o_merge_cnt); end
        repeat ((1 << CNT_BW) + 3 - 100) @(negedge clk);
        bus.dramw_rdy = 1'b0;
        #1;
        total++; if (bus.o_merge_cnt !== 16'hFFFF) begin bad++; $display("[TB] FAIL sat_final got=%h want=ffff", bus.o_merge_cnt); end
        total++; if (bus.o_mema !== 32'h60) begin bad++; $display("[TB] FAIL sat_head got=%h want=00000060", bus.o_mema); end
        bus.mem_ack = 1'b1;
        @(negedge clk);
        #1;
        total++; if (bus.o_mema !== 32'h70 || bus.o_memd[0] !== 16'h0008) begin bad++; $display("[TB] FAIL sat_tail got=%h d0=%h want=00000070 d0=0008", bus.o_mema, bus.o_memd[0]); end
        @(negedge clk);
        bus.mem_ack = 1'b0;
        #1;
        total++; if (bus.o_idle !== 1'b1) begin bad++; $display("[TB] FAIL sat_idle got=%0b want=1", bus.o_idle); end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_req(32'h200 + 32'(i) * 32'h10, 32'hFFFF_FFFF, 16'h00EE);
        end
        @(negedge clk);
        bus.dramw_rdy = 1'b0;
        #1;
        total++; if (bus.mem_rdy !== 1'b1) begin bad++; $display("[TB] FAIL mr_pending got=%0b want=1", bus.mem_rdy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (bus.mem_rdy !== 1'b0) begin bad++; $display("[TB] FAIL mr_mem_rdy got=%0b want=0", bus.mem_rdy); end
        total++; if (bus.o_idle !== 1'b1) begin bad++; $display("[TB] FAIL mr_idle got=%0b want=1", bus.o_idle); end
        total++; if (bus.o_merge_cnt !== 16'd0) begin bad++; $display("[TB] FAIL mr_cnt got=%0d want=0", bus.o_merge_cnt); end
        set_req(32'h300, 32'hFFFF_FFFF, 16'h0077);
        @(negedge clk);
        bus.dramw_rdy = 1'b0;
        #1;
        total++; if (bus.o_mema !== 32'h300 || bus.mem_rdy !== 1'b1) begin bad++; $display("[TB] FAIL mr_first got=%h rdy=%0b want=00000300", bus.o_mema, bus.mem_rdy); end
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        #1;
        total++; if (bus.o_idle !== 1'b1) begin bad++; $display("[TB] FAIL mr_drain got=%0b want=1", bus.o_idle); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.dramw_rdy    = 1'b0;
        bus.mem_ack      = 1'b0;
        bus.i_dramwa     = '0;
        bus.i_dramw_mask = '0;
        for (int i = 0; i < CSIZE; i++) bus.i_dramwd[i] = '0;
        $display("[TB] start");
        test_reset();
        test_passthrough();
        test_merge();
        test_head_protection();
        test_backpressure();
        test_back_to_back();
        test_zero_mask_saturation();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
